// File: rtl/split4.sv
// split4: packs a stream of IN_WIDTH-bit words into groups of up to four
// output lanes. A group closes on its fourth word or on s_last, and is
// presented as a registered, ready/valid-handshaked output group.
module split4 #(
  parameter int IN_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_data,
  input  logic                s_last,
  output logic [IN_WIDTH-1:0] d0_o,
  output logic [IN_WIDTH-1:0] d1_o,
  output logic [IN_WIDTH-1:0] d2_o,
  output logic [IN_WIDTH-1:0] d3_o,
  output logic [2:0]          m_cnt,
  output logic                m_valid,
  input  logic                m_ready
);

  logic [1:0]          cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] buf0_q, buf0_d;
  logic [IN_WIDTH-1:0] buf1_q, buf1_d;
  logic [IN_WIDTH-1:0] buf2_q, buf2_d;
  logic [IN_WIDTH-1:0] d0_q, d0_d;
  logic [IN_WIDTH-1:0] d1_q, d1_d;
  logic [IN_WIDTH-1:0] d2_q, d2_d;
  logic [IN_WIDTH-1:0] d3_q, d3_d;
  logic [2:0]          m_cnt_q, m_cnt_d;
  logic                m_valid_q, m_valid_d;

  logic closing_possible;
  logic accept;
  logic close;

  // Handshake: only a word that would close a group must wait for the
  // output register to be free; s_data never feeds s_ready.
  always_comb begin
    closing_possible = (cnt_q == 2'd3) || s_last;
    s_ready          = !(m_valid_q && !m_ready) || !closing_possible;
    accept           = s_valid && s_ready;
    close            = accept && closing_possible;
  end

  // Next-state: collect words into the buffer, or load the output group on close.
  always_comb begin
    cnt_d     = cnt_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf2_d    = buf2_q;
    d0_d      = d0_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    d3_d      = d3_q;
    m_cnt_d   = m_cnt_q;
    m_valid_d = m_valid_q;
    if (close) begin
      // Closing word comes straight from s_data; lanes past it are zeroed.
      d0_d      = (cnt_q == 2'd0) ? s_data : buf0_q;
      d1_d      = (cnt_q == 2'd1) ? s_data : ((cnt_q > 2'd1) ? buf1_q : '0);
      d2_d      = (cnt_q == 2'd2) ? s_data : ((cnt_q == 2'd3) ? buf2_q : '0);
      d3_d      = (cnt_q == 2'd3) ? s_data : '0;
      m_cnt_d   = {1'b0, cnt_q} + 3'd1;
      m_valid_d = 1'b1;
      cnt_d     = 2'd0;
    end else begin
      if (accept) begin
        case (cnt_q)
          2'd0:    buf0_d = s_data;
          2'd1:    buf1_d = s_data;
          default: buf2_d = s_data;
        endcase
        cnt_d = cnt_q + 2'd1;
      end
      if (m_valid_q && m_ready) begin
        m_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      buf2_q    <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      m_cnt_q   <= 3'd0;
      m_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      buf2_q    <= buf2_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      m_cnt_q   <= m_cnt_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign d0_o    = d0_q;
  assign d1_o    = d1_q;
  assign d2_o    = d2_q;
  assign d3_o    = d3_q;
  assign m_cnt   = m_cnt_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_split4.sv
// tb_split4: directed scenarios plus a randomized scoreboard run for split4.
module tb_split4;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         s_last = 1'b0;
  logic [W-1:0] d0_o, d1_o, d2_o, d3_o;
  logic [2:0]   m_cnt;
  logic         m_valid;
  logic         m_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  split4 #(.IN_WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .d0_o   (d0_o),
    .d1_o   (d1_o),
    .d2_o   (d2_o),
    .d3_o   (d3_o),
    .m_cnt  (m_cnt),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef logic [4*W+3:0] outv_t;

  function automatic outv_t outs_pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] c, input logic [W-1:0] d,
                                      input logic [2:0] n, input logic v);
    return {a, b, c, d, n, v};
  endfunction

  task automatic test_reset();
    outv_t got;
    #2 rst = 1'b0;
    #1;
    got = {d0_o, d1_o, d2_o, d3_o, m_cnt, m_valid};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_s_ready got=%b exp=1", s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_group();
    logic [W-1:0] w [4];
    outv_t got, exp;
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = w[i]; s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    got = {d0_o, d1_o, d2_o, d3_o, m_cnt, m_valid};
    exp = outs_pack(32'h11, 32'h22, 32'h33, 32'h44, 3'd4, 1'b1);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL full_group got=%h exp=%h", got, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_group_one_cycle m_valid got=%b exp=0", m_valid);
    end
  endtask

  task automatic test_partial();
    outv_t got, exp;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'hA; s_last = 1'b0;
    @(posedge clk); #1;
    s_data = 32'hB; s_last = 1'b1;
    @(posedge clk); #1;
    s_data = 32'hC; s_last = 1'b1;
    got = {d0_o, d1_o, d2_o, d3_o, m_cnt, m_valid};
    exp = outs_pack(32'hA, 32'hB, 32'h0, 32'h0, 3'd2, 1'b1);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL partial_group got=%h exp=%h", got, exp);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    got = {d0_o, d1_o, d2_o, d3_o, m_cnt, m_valid};
    exp = outs_pack(32'hC, 32'h0, 32'h0, 32'h0, 3'd1, 1'b1);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL partial_next_lane0 got=%h exp=%h", got, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    outv_t got, exp1, exp2;
    exp1 = outs_pack(32'h101, 32'h102, 32'h103, 32'h104, 3'd4, 1'b1);
    exp2 = outs_pack(32'h105, 32'h106, 32'h107, 32'h108, 3'd4, 1'b1);
    m_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + W'(i); s_last = 1'b0;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
        failures++;
        $display("FAIL stall_accept_word%0d s_ready got=%b exp=1", i, s_ready);
      end
      @(posedge clk); #1;
    end
    s_data = 32'h108;
    for (int k = 0; k < 3; k++) begin
      #1;
      got = {d0_o, d1_o, d2_o, d3_o, m_cnt, m_valid};
      checks++;
      if (s_ready !== 1'b0 || got !== exp1) begin
        failures++;
        $display("FAIL stall_hold cyc%0d s_ready=%b out=%h exp_ready=0 exp_out=%h", k, s_ready, got, exp1);
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release s_ready got=%b exp=1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    got = {d0_o, d1_o, d2_o, d3_o, m_cnt, m_valid};
    checks++;
    if (got !== exp2) begin
      failures++;
      $display("FAIL stall_group2 got=%h exp=%h", got, exp2);
    end
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain m_valid got=%b exp=0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    outv_t got, exp;
    logic exp_v;
    int g;
    m_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      s_valid = (c <= 12); s_data = 32'h200 + W'(c - 1); s_last = 1'b0;
      exp_v = (c == 5 || c == 9 || c == 13);
      checks++;
      if (m_valid !== exp_v) begin
        failures++;
        $display("FAIL b2b_valid cyc%0d got=%b exp=%b", c, m_valid, exp_v);
      end
      if (exp_v) begin
        g = (c - 5);
        got = {d0_o, d1_o, d2_o, d3_o, m_cnt, m_valid};
        exp = outs_pack(32'h200 + W'(g), 32'h201 + W'(g), 32'h202 + W'(g), 32'h203 + W'(g), 3'd4, 1'b1);
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL b2b_group cyc%0d got=%h exp=%h", c, got, exp);
        end
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    outv_t got, exp;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = 32'h301 + W'(i); s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    got = {d0_o, d1_o, d2_o, d3_o, m_cnt, m_valid};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h exp=0", got);
    end
    #3 rst = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'h401 + W'(i); s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    got = {d0_o, d1_o, d2_o, d3_o, m_cnt, m_valid};
    exp = outs_pack(32'h401, 32'h402, 32'h403, 32'h404, 3'd4, 1'b1);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL async_reset_clean_group got=%h exp=%h", got, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] words_q [$];
    int           sizes_q [$];
    logic [W-1:0] lanes [4];
    logic [W-1:0] ew;
    int sent, cyc, mcnt, esz, bad, nwords, limit;
    nwords = 10000; limit = 80000;
    sent = 0; cyc = 0; mcnt = 0;
    while ((sent < nwords || sizes_q.size() > 0 || m_valid) && cyc < limit) begin
      m_ready = ($urandom_range(3) != 0) || (sent >= nwords);
      if (sent < nwords) begin
        if (!s_valid || s_ready) begin
          s_valid = ($urandom_range(3) != 0);
          s_data  = $urandom;
          s_last  = ($urandom_range(7) == 0) || (sent == nwords - 1);
        end
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      #1;
      if (m_valid && m_ready) begin
        lanes[0] = d0_o; lanes[1] = d1_o; lanes[2] = d2_o; lanes[3] = d3_o;
        esz = (sizes_q.size() > 0) ? sizes_q.pop_front() : 0;
        bad = (int'(m_cnt) != esz) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
          if (i < esz) begin
            ew = (words_q.size() > 0) ? words_q.pop_front() : '0;
            if (lanes[i] !== ew) bad = 1;
          end else if (lanes[i] !== '0) begin
            bad = 1;
          end
        end
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL random_group cyc%0d m_cnt=%0d exp_cnt=%0d lanes=%h %h %h %h",
                   cyc, m_cnt, esz, d0_o, d1_o, d2_o, d3_o);
        end
      end
      if (s_valid && s_ready) begin
        words_q.push_back(s_data);
        sent++;
        if (mcnt == 3 || s_last) begin
          sizes_q.push_back(mcnt + 1);
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
      @(posedge clk); #1;
      if (sent >= nwords) s_valid = 1'b0;
      cyc++;
    end
    s_valid = 1'b0;
    checks++;
    if (cyc >= limit || words_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain cycles=%0d leftover_words=%0d exp_leftover=0", cyc, words_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_partial();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
